pipe_ctrl: RTL and testbench

- Central pipeline control: producer of the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, and of the branch flush.
- Merges level stall requests from ID/EX with multi-cycle req/done handshakes from instruction fetch and data memory.
- Tracks outstanding accesses, flags runaway stalls, and keeps stall/flush performance counters.

---
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Central pipeline control: merges hazard stalls and fetch/memory handshakes into the
// per-stage stall vector and branch flush, with a stall watchdog and performance counters.
module pipe_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             if_req,
    input  logic             if_done,
    input  logic             mem_req,
    input  logic             mem_done,
    input  logic             ex_jump_flag,
    output logic [5:0]       stall,
    output logic             flush,
    output logic             if_discard,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int RUN_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_IF   = 2'd1,
        WAIT_MEM  = 2'd2,
        WAIT_BOTH = 2'd3
    } state_t;

    state_t           state_reg;
    logic             if_discard_reg;
    logic             timeout_err_reg;
    logic [RUN_W-1:0] run_cnt_reg;
    logic [CNT_W-1:0] stall_cycles_reg;
    logic [CNT_W-1:0] flush_count_reg;

    logic       if_pending;
    logic       mem_pending;
    logic       if_pending_next;
    logic       mem_pending_next;
    logic       if_stall;
    logic       mem_stall;
    logic [5:0] stall_next;
    logic       flush_next;

    always_comb begin
        if_pending  = (state_reg == WAIT_IF)  || (state_reg == WAIT_BOTH);
        mem_pending = (state_reg == WAIT_MEM) || (state_reg == WAIT_BOTH);

        // A done in the same cycle as its req (or while pending) ends the wait immediately.
        if_pending_next  = (if_pending  | if_req)  & ~if_done;
        mem_pending_next = (mem_pending | mem_req) & ~mem_done;
        if_stall         = if_pending_next;
        mem_stall        = mem_pending_next;

        if (mem_stall)
            stall_next = 6'b011111;
        else if (stallreq_ex)
            stall_next = 6'b001111;
        else if (stallreq_id)
            stall_next = 6'b000111;
        else if (if_stall)
            stall_next = 6'b000011;
        else
            stall_next = 6'b000000;

        // A jump parked in EX behind a memory stall flushes only when EX/MEM advances.
        flush_next = ex_jump_flag & ~stall_next[3];
    end

    assign stall        = stall_next;
    assign flush        = flush_next;
    assign if_discard   = if_discard_reg;
    assign timeout_err  = timeout_err_reg;
    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= RUN;
            if_discard_reg   <= 1'b0;
            timeout_err_reg  <= 1'b0;
            run_cnt_reg      <= '0;
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            case ({mem_pending_next, if_pending_next})
                2'b00:   state_reg <= RUN;
                2'b01:   state_reg <= WAIT_IF;
                2'b10:   state_reg <= WAIT_MEM;
                default: state_reg <= WAIT_BOTH;
            endcase

            // Fetch still outstanding across a flush will return wrong-path data.
            if (flush_next && if_stall)
                if_discard_reg <= 1'b1;
            else if (if_done)
                if_discard_reg <= 1'b0;

            if (stall_next[0]) begin
                if (run_cnt_reg != RUN_MAX)
                    run_cnt_reg <= run_cnt_reg + RUN_W'(1);
                if (run_cnt_reg == RUN_MAX - RUN_W'(1))
                    timeout_err_reg <= 1'b1;
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            end else begin
                run_cnt_reg <= '0;
            end

            if (flush_next)
                flush_count_reg <= flush_count_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with hand-computed expectations; TIMEOUT shrunk to 8.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, if_req, if_done, mem_req, mem_done, ex_jump_flag;
    logic [5:0]  stall;
    logic        flush, if_discard, timeout_err;
    logic [31:0] stall_cycles, flush_count;

    int tests_run = 0;
    int tests_failed = 0;

    pipe_ctrl #(.TIMEOUT(8), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .if_req       (if_req),
        .if_done      (if_done),
        .mem_req      (mem_req),
        .mem_done     (mem_done),
        .ex_jump_flag (ex_jump_flag),
        .stall        (stall),
        .flush        (flush),
        .if_discard   (if_discard),
        .timeout_err  (timeout_err),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    // Apply one cycle of inputs just after a rising edge; comb outputs are checked at the
    // following falling edge, registered outputs after the next rising edge.
    task automatic drive(input logic r, input logic id, input logic ex, input logic ireq,
                         input logic idone, input logic mreq, input logic mdone, input logic jmp);
        rst = r; stallreq_id = id; stallreq_ex = ex; if_req = ireq; if_done = idone;
        mem_req = mreq; mem_done = mdone; ex_jump_flag = jmp;
        @(negedge clk);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
            check($sformatf("idle_stall_%0d", i), 32'(stall), 32'h0);
            check($sformatf("idle_flush_%0d", i), 32'(flush), 32'h0);
            tick();
        end
        check("idle_stall_cycles", stall_cycles, 32'd0);
        check("idle_flush_count", flush_count, 32'd0);
        check("idle_timeout", 32'(timeout_err), 32'd0);
        check("idle_discard", 32'(if_discard), 32'd0);

        // Memory access with 3-cycle wait
        drive(1'b1, 0, 0, 0, 0, 1, 0, 0); check("mem_req_stall", 32'(stall), 32'h1f); tick();
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0); check("mem_wait1_stall", 32'(stall), 32'h1f); tick();
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0); check("mem_wait2_stall", 32'(stall), 32'h1f); tick();
        drive(1'b1, 0, 0, 0, 0, 0, 1, 0); check("mem_done_stall", 32'(stall), 32'h00); tick();
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0); check("mem_after_stall", 32'(stall), 32'h00); tick();
        check("mem_stall_cycles", stall_cycles, 32'd3);

        // Priority: fetch pending, ID hazard, then memory access on top
        drive(1'b1, 0, 0, 1, 0, 0, 0, 0); check("prio_if_stall", 32'(stall), 32'h03); tick();
        drive(1'b1, 1, 0, 0, 0, 0, 0, 0); check("prio_id_stall", 32'(stall), 32'h07); tick();
        drive(1'b1, 1, 0, 0, 0, 1, 0, 0); check("prio_mem_stall", 32'(stall), 32'h1f); tick();
        drive(1'b1, 0, 0, 0, 1, 0, 1, 0); check("prio_done_stall", 32'(stall), 32'h00); tick();
        drive(1'b1, 0, 0, 1, 1, 0, 0, 0); check("zero_wait_stall", 32'(stall), 32'h00); tick();
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0); check("zero_wait_after", 32'(stall), 32'h00); tick();
        check("prio_stall_cycles", stall_cycles, 32'd6);

        // Jump held behind a memory stall flushes exactly once
        drive(1'b1, 0, 0, 0, 0, 1, 0, 1); check("jmp_hold1_flush", 32'(flush), 32'h0); tick();
        drive(1'b1, 0, 0, 0, 0, 0, 0, 1); check("jmp_hold2_flush", 32'(flush), 32'h0); tick();
        drive(1'b1, 0, 0, 0, 0, 0, 1, 1); check("jmp_release_flush", 32'(flush), 32'h1);
        check("jmp_release_stall", 32'(stall), 32'h00); tick();
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0); check("jmp_after_flush", 32'(flush), 32'h0); tick();
        check("jmp_flush_count", flush_count, 32'd1);
        check("jmp_no_discard", 32'(if_discard), 32'd0);

        // Flush with a fetch outstanding marks its data for discard
        drive(1'b1, 0, 0, 1, 0, 0, 0, 0); check("disc_req_stall", 32'(stall), 32'h03); tick();
        check("disc_before", 32'(if_discard), 32'd0);
        drive(1'b1, 0, 0, 0, 0, 0, 0, 1); check("disc_flush", 32'(flush), 32'h1); tick();
        check("disc_set", 32'(if_discard), 32'd1);
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0); check("disc_wait_stall", 32'(stall), 32'h03); tick();
        check("disc_hold", 32'(if_discard), 32'd1);
        drive(1'b1, 0, 0, 0, 1, 0, 0, 0); check("disc_done_stall", 32'(stall), 32'h00); tick();
        check("disc_clear", 32'(if_discard), 32'd0);
        check("disc_flush_count", flush_count, 32'd2);
        check("disc_stall_cycles", stall_cycles, 32'd11);

        // Watchdog: 10 consecutive EX stalls with TIMEOUT=8
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 0, 1, 0, 0, 0, 0, 0);
            check($sformatf("wd_stall_%0d", k), 32'(stall), 32'h0f);
            tick();
            check($sformatf("wd_err_%0d", k), 32'(timeout_err), (k >= 8) ? 32'd1 : 32'd0);
        end
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0); check("wd_release_stall", 32'(stall), 32'h00); tick();
        check("wd_sticky", 32'(timeout_err), 32'd1);
        check("wd_stall_cycles", stall_cycles, 32'd21);

        // Reset in the middle of a memory access; the late done must be ignored
        drive(1'b1, 0, 0, 0, 0, 1, 0, 0); check("rst_mem_stall", 32'(stall), 32'h1f); tick();
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0); tick();
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
        check("rst_flush_count", flush_count, 32'd0);
        check("rst_discard", 32'(if_discard), 32'd0);
        check("rst_stall", 32'(stall), 32'h00);
        check("rst_flush", 32'(flush), 32'h0);
        drive(1'b1, 0, 0, 0, 0, 0, 1, 0); check("late_done_stall", 32'(stall), 32'h00); tick();
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0); check("late_after_stall", 32'(stall), 32'h00); tick();
        check("late_stall_cycles", stall_cycles, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
